// File: rtl/cd_div_pkg.sv
// rtl/cd_div_pkg.sv - shared types and default widths for the 12/4 restoring divider
package cd_div_pkg;

    localparam int DEF_DW = 12;
    localparam int DEF_VW = 4;
    localparam int DEF_QW = 8;
    localparam int CNT_W  = $clog2(DEF_QW);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cd_div12x4_if.sv
// rtl/cd_div12x4_if.sv - operand/result handshake bundle for cd_div12x4
interface cd_div12x4_if #(
    parameter int DW = cd_div_pkg::DEF_DW,
    parameter int VW = cd_div_pkg::DEF_VW,
    parameter int QW = cd_div_pkg::DEF_QW
);

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          out_valid;
    logic          out_ready;
    logic [QW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_zero;
    logic          ovf;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_zero, ovf
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_zero, ovf
    );

endinterface

// File: rtl/cd_div_step.sv
// rtl/cd_div_step.sv - one combinational restoring-division step
module cd_div_step #(
    parameter int VW = cd_div_pkg::DEF_VW
) (
    input  logic [VW-1:0] rem,
    input  logic          bit_in,
    input  logic [VW-1:0] divisor,
    output logic [VW-1:0] rem_next,
    output logic          qbit
);

    logic [VW:0] trial;
    logic [VW:0] diff;

    // rem < divisor on entry, so trial < 2*divisor and the difference fits VW bits
    assign trial    = {rem, bit_in};
    assign diff     = trial - {1'b0, divisor};
    assign qbit     = (trial >= {1'b0, divisor});
    assign rem_next = qbit ? diff[VW-1:0] : trial[VW-1:0];

endmodule

// File: rtl/cd_div12x4.sv
// rtl/cd_div12x4.sv - sequential 12-bit by 4-bit restoring divider, one quotient bit per clock
module cd_div12x4
    import cd_div_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int VW = DEF_VW,
    parameter int QW = DEF_QW
) (
    input  logic         clk,
    input  logic         rst_n,
    cd_div12x4_if.slave  bus
);

    localparam int CW = $clog2(QW);

    state_t        state_q;
    state_t        state_d;
    logic [QW-1:0] quot_q;
    logic [QW-1:0] shift_q;
    logic [VW-1:0] rem_q;
    logic [VW-1:0] div_q;
    logic [CW-1:0] cnt_q;
    logic          dz_q;
    logic          ovf_q;

    logic          accept;
    logic          pre_dz;
    logic          pre_ovf;
    logic [VW-1:0] step_rem;
    logic          step_qbit;

    assign accept  = bus.in_valid && (state_q == IDLE);
    assign pre_dz  = (bus.divisor == '0);
    // quotient overflows exactly when the top VW dividend bits already reach the divisor
    assign pre_ovf = !pre_dz && (bus.dividend[DW-1:QW] >= bus.divisor);

    cd_div_step #(.VW(VW)) u_step (
        .rem      (rem_q),
        .bit_in   (shift_q[QW-1]),
        .divisor  (div_q),
        .rem_next (step_rem),
        .qbit     (step_qbit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (pre_dz || pre_ovf) ? DONE : RUN;
                end
            end
            RUN: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quot_q  <= '0;
            shift_q <= '0;
            rem_q   <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        div_q <= bus.divisor;
                        if (pre_dz || pre_ovf) begin
                            quot_q <= '1;
                            rem_q  <= '0;
                            dz_q   <= pre_dz;
                            ovf_q  <= pre_ovf;
                        end else begin
                            quot_q  <= '0;
                            rem_q   <= bus.dividend[DW-1:QW];
                            shift_q <= bus.dividend[QW-1:0];
                            cnt_q   <= CW'(QW - 1);
                            dz_q    <= 1'b0;
                            ovf_q   <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    rem_q   <= step_rem;
                    quot_q  <= {quot_q[QW-2:0], step_qbit};
                    shift_q <= {shift_q[QW-2:0], 1'b0};
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.quotient  = quot_q;
    assign bus.remainder = rem_q;
    assign bus.div_zero  = dz_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_cd_div12x4.sv
// tb/tb_cd_div12x4.sv - directed and random-vector bench for cd_div12x4
module tb_cd_div12x4;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    int   accepts;
    int   ops_issued;

    cd_div12x4_if dif ();

    cd_div12x4 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && dif.in_valid && dif.in_ready) begin
            accepts <= accepts + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge; returns just after the falling edge following the result handshake.
    task automatic run_op(input logic [11:0] a, input logic [3:0] b, input int stall, input bit hold,
                          input logic [7:0] eq, input logic [3:0] er, input logic edz, input logic eovf,
                          input string tag);
        int lat;
        int exp_lat;
        exp_lat = (edz || eovf) ? 0 : 8;
        ops_issued++;
        dif.dividend  = a;
        dif.divisor   = b;
        dif.in_valid  = 1'b1;
        dif.out_ready = (stall == 0);
        check({tag, ".in_ready_idle"}, dif.in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        if (!hold) dif.in_valid = 1'b0;
        dif.dividend = ~a;
        dif.divisor  = ~b;
        lat = 0;
        while (dif.out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ".latency"}, lat, exp_lat);
        check({tag, ".quotient"}, dif.quotient, eq);
        check({tag, ".remainder"}, dif.remainder, er);
        check({tag, ".div_zero"}, dif.div_zero, edz);
        check({tag, ".ovf"}, dif.ovf, eovf);
        check({tag, ".in_ready_done"}, dif.in_ready, 0);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check({tag, ".stall_hold"}, {dif.quotient, dif.remainder, dif.out_valid, dif.in_ready},
                  {eq, er, 1'b1, 1'b0});
        end
        dif.out_ready = 1'b1;
        @(negedge clk);
        check({tag, ".out_valid_after"}, dif.out_valid, 0);
        check({tag, ".in_ready_after"}, dif.in_ready, 1);
    endtask

    initial begin
        logic        seen_ov;
        logic [11:0] ra;
        logic [3:0]  rb;
        logic [7:0]  rq;
        logic [3:0]  rr;
        logic        rdz;
        logic        rovf;
        int          qfull;

        n_vec = 0;
        n_err = 0;
        accepts = 0;
        ops_issued = 0;
        rst_n = 1'b0;
        dif.in_valid = 1'b0;
        dif.out_ready = 1'b1;
        dif.dividend = '0;
        dif.divisor = '0;
        repeat (2) @(negedge clk);
        check("reset.in_ready", dif.in_ready, 1);
        check("reset.out_valid", dif.out_valid, 0);
        check("reset.quotient", dif.quotient, 0);
        check("reset.remainder", dif.remainder, 0);
        check("reset.flags", {dif.div_zero, dif.ovf}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(12'd3825, 4'd15, 0, 0, 8'd255, 4'd0, 0, 0, "d3825_15");
        run_op(12'd1000, 4'd7,  0, 0, 8'd142, 4'd6, 0, 0, "d1000_7");
        run_op(12'd0,    4'd9,  0, 0, 8'd0,   4'd0, 0, 0, "d0_9");
        run_op(12'd100,  4'd0,  0, 0, 8'hFF,  4'd0, 1, 0, "d100_0");
        run_op(12'd4095, 4'd1,  0, 0, 8'hFF,  4'd0, 0, 1, "d4095_1");
        run_op(12'd200,  4'd3,  5, 0, 8'd66,  4'd2, 0, 0, "d200_3_stall");
        run_op(12'd255,  4'd1,  0, 0, 8'd255, 4'd0, 0, 0, "d255_1");
        run_op(12'd256,  4'd1,  0, 0, 8'hFF,  4'd0, 0, 1, "d256_1");
        run_op(12'd3839, 4'd15, 0, 0, 8'd255, 4'd14, 0, 0, "d3839_15");
        run_op(12'd3840, 4'd15, 0, 0, 8'hFF,  4'd0, 0, 1, "d3840_15");
        run_op(12'd77,   4'd5,  0, 1, 8'd15,  4'd2, 0, 0, "hold_77_5");
        run_op(12'd123,  4'd4,  2, 1, 8'd30,  4'd3, 0, 0, "hold_123_4");
        dif.in_valid = 1'b0;
        check("hold.accepts", accepts, ops_issued);

        dif.dividend = 12'd500;
        dif.divisor = 4'd9;
        dif.in_valid = 1'b1;
        ops_issued++;
        @(posedge clk);
        @(negedge clk);
        dif.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst.out_valid", dif.out_valid, 0);
        check("midrst.in_ready", dif.in_ready, 1);
        check("midrst.quot_rem", {dif.quotient, dif.remainder}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_ov = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            seen_ov = seen_ov | dif.out_valid;
        end
        check("midrst.no_result", seen_ov, 0);
        run_op(12'd500, 4'd9, 0, 0, 8'd55, 4'd5, 0, 0, "d500_9_after_rst");

        for (int k = 0; k < 150; k++) begin
            ra = 12'($urandom_range(0, 4095));
            rb = 4'($urandom_range(0, 15));
            if (rb == 0) begin
                rq = 8'hFF; rr = 4'd0; rdz = 1'b1; rovf = 1'b0;
            end else begin
                qfull = int'(ra) / int'(rb);
                rdz = 1'b0;
                if (qfull > 255) begin
                    rq = 8'hFF; rr = 4'd0; rovf = 1'b1;
                end else begin
                    rq = 8'(qfull); rr = 4'(int'(ra) % int'(rb)); rovf = 1'b0;
                end
            end
            run_op(ra, rb, 0, 0, rq, rr, rdz, rovf, "rand");
        end
        check("total.accepts", accepts, ops_issued);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
